// File: rtl/wb_write_arbiter.sv
// Merges ALU and load-unit results onto the single regfile write port; loads are queued, ALU has priority.
// Latency 1 cycle to the registered write port. Define WB_FWD_EN to forward youngest pending data on oChkData.
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               iClk,
  input  logic                               iReset_n,
  input  logic                               iAluValid,
  output logic                               oAluReady,
  input  logic [ADDR_W-1:0]                  iAluAddr,
  input  logic [DATA_W-1:0]                  iAluData,
  input  logic                               iMemValid,
  output logic                               oMemReady,
  input  logic [ADDR_W-1:0]                  iMemAddr,
  input  logic [DATA_W-1:0]                  iMemData,
  output logic                               oWe,
  output logic [ADDR_W-1:0]                  oWaddr,
  output logic [DATA_W-1:0]                  oWdata,
  input  logic [ADDR_W-1:0]                  iChkAddr,
  output logic                               oChkHit,
  output logic [DATA_W-1:0]                  oChkData,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    oPending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              full, empty, alu_hs, mem_hs;
  logic              push, pop, iss_vld;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_data;
  logic              chk_hit;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign oAluReady = !full;
  assign oMemReady = !full;
  assign alu_hs    = iAluValid && !full;
  assign mem_hs    = iMemValid && !full;

  // Issue selection: full FIFO drains first so a blocked load stream cannot starve behind the ALU.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    iss_vld  = 1'b0;
    iss_addr = '0;
    iss_data = '0;
    if (full) begin
      pop      = 1'b1;
      iss_vld  = 1'b1;
      iss_addr = fifo_addr_q[rd_ptr_q];
      iss_data = fifo_data_q[rd_ptr_q];
    end else if (alu_hs) begin
      iss_vld  = 1'b1;
      iss_addr = iAluAddr;
      iss_data = iAluData;
      push     = mem_hs;
    end else if (!empty) begin
      pop      = 1'b1;
      iss_vld  = 1'b1;
      iss_addr = fifo_addr_q[rd_ptr_q];
      iss_data = fifo_data_q[rd_ptr_q];
      push     = mem_hs;
    end else if (mem_hs) begin
      iss_vld  = 1'b1;
      iss_addr = iMemAddr;
      iss_data = iMemData;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    // Writes to r0 are consumed but never reach the regfile.
    we_d    = iss_vld && (iss_addr != '0);
    waddr_d = we_d ? iss_addr : waddr_q;
    wdata_d = we_d ? iss_data : wdata_q;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= iMemAddr;
      fifo_data_q[wr_ptr_q] <= iMemData;
    end
  end

`ifdef WB_FWD_EN
  logic [DATA_W-1:0] chk_data;

  // Scan oldest to newest so the last match wins, i.e. the youngest pending write.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    if (iChkAddr != '0) begin
      if (we_q && (waddr_q == iChkAddr)) begin
        chk_hit  = 1'b1;
        chk_data = wdata_q;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if ((CNT_W'(k) < count_q) && (fifo_addr_q[rd_ptr_q + PTR_W'(k)] == iChkAddr)) begin
          chk_hit  = 1'b1;
          chk_data = fifo_data_q[rd_ptr_q + PTR_W'(k)];
        end
      end
    end
  end

  assign oChkData = chk_data;
`else
  always_comb begin
    chk_hit = 1'b0;
    if (iChkAddr != '0) begin
      if (we_q && (waddr_q == iChkAddr)) begin
        chk_hit = 1'b1;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if ((CNT_W'(k) < count_q) && (fifo_addr_q[rd_ptr_q + PTR_W'(k)] == iChkAddr)) begin
          chk_hit = 1'b1;
        end
      end
    end
  end

  assign oChkData = '0;
`endif

  assign oChkHit  = chk_hit;
  assign oWe      = we_q;
  assign oWaddr   = waddr_q;
  assign oWdata   = wdata_q;
  assign oPending = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic          iClk = 1'b0;
  logic          iReset_n = 1'b1;
  logic          iAluValid = 1'b0, iMemValid = 1'b0;
  logic [AW-1:0] iAluAddr = '0, iMemAddr = '0, iChkAddr = '0;
  logic [DW-1:0] iAluData = '0, iMemData = '0;
  logic          oAluReady, oMemReady, oWe, oChkHit;
  logic [AW-1:0] oWaddr;
  logic [DW-1:0] oWdata, oChkData;
  logic [2:0]    oPending;

  int errors = 0;
  int checks = 0;

  // Reference model: pending loads in arrival order plus the registered write port.
  logic [AW-1:0] mq_a[$];
  logic [DW-1:0] mq_d[$];
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_alu_acc, m_mem_acc;

  always #5 iClk = ~iClk;

  wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluAddr(iAluAddr), .iAluData(iAluData),
    .iMemValid(iMemValid), .oMemReady(oMemReady), .iMemAddr(iMemAddr), .iMemData(iMemData),
    .oWe(oWe), .oWaddr(oWaddr), .oWdata(oWdata),
    .iChkAddr(iChkAddr), .oChkHit(oChkHit), .oChkData(oChkData), .oPending(oPending)
  );

  task automatic model_reset();
    mq_a.delete();
    mq_d.delete();
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic void model_chk(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d = '0;
    if (a != '0) begin
      if (m_we && m_waddr == a) begin hit = 1'b1; d = m_wdata; end
      foreach (mq_a[i]) if (mq_a[i] == a) begin hit = 1'b1; d = mq_d[i]; end
    end
`ifndef WB_FWD_EN
    d = '0;
`endif
  endfunction

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    iAluValid = av; iAluAddr = aa; iAluData = ad;
    iMemValid = mv; iMemAddr = ma; iMemData = md;
  endtask

  // One clock edge; the model applies the issue rules to the inputs held across that edge.
  task automatic cycle();
    bit full, iss;
    logic [AW-1:0] ia;
    logic [DW-1:0] id;
    @(posedge iClk);
    #1;
    full = (mq_a.size() == D);
    m_alu_acc = iAluValid && !full;
    m_mem_acc = iMemValid && !full;
    iss = 1'b0; ia = '0; id = '0;
    if (full) begin
      iss = 1'b1; ia = mq_a.pop_front(); id = mq_d.pop_front();
    end else if (m_alu_acc) begin
      iss = 1'b1; ia = iAluAddr; id = iAluData;
      if (m_mem_acc) begin mq_a.push_back(iMemAddr); mq_d.push_back(iMemData); end
    end else if (mq_a.size() != 0) begin
      iss = 1'b1; ia = mq_a.pop_front(); id = mq_d.pop_front();
      if (m_mem_acc) begin mq_a.push_back(iMemAddr); mq_d.push_back(iMemData); end
    end else if (m_mem_acc) begin
      iss = 1'b1; ia = iMemAddr; id = iMemData;
    end
    m_we = iss && (ia != '0);
    if (m_we) begin m_waddr = ia; m_wdata = id; end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    iChkAddr = 5;
    #2 iReset_n = 1'b0;
    model_reset();
    #10;
    checks++; if (oWe !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", oWe); end
    checks++; if (oWaddr !== '0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", oWaddr); end
    checks++; if (oWdata !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", oWdata); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", oPending); end
    checks++; if (oAluReady !== 1'b1 || oMemReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b%0b exp=11", oAluReady, oMemReady); end
    checks++; if (oChkHit !== 1'b0 || oChkData !== '0) begin errors++; $display("FAIL reset_chk got=%0b/%h exp=0/0", oChkHit, oChkData); end
    @(posedge iClk); #1 iReset_n = 1'b1;
  endtask

  task automatic test_alu_write();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    checks++; if (oWe !== 1'b1 || oWaddr !== 5'd5 || oWdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write got=%0b/%0d/%h exp=1/5/deadbeef", oWe, oWaddr, oWdata); end
    drive(1, 0, 32'h1, 0, 0, 0);
    cycle();
    checks++; if (oWe !== 1'b0) begin errors++; $display("FAIL alu_r0_we got=%0b exp=0", oWe); end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_alu_and_load();
    drive(1, 3, 32'h11, 1, 4, 32'h22);
    cycle();
    checks++; if (oWe !== 1'b1 || oWaddr !== 5'd3 || oWdata !== 32'h11) begin
      errors++; $display("FAIL both_first got=%0b/%0d/%h exp=1/3/11", oWe, oWaddr, oWdata); end
    checks++; if (oPending !== 3'd1) begin errors++; $display("FAIL both_pend1 got=%0d exp=1", oPending); end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    checks++; if (oWe !== 1'b1 || oWaddr !== 5'd4 || oWdata !== 32'h22) begin
      errors++; $display("FAIL both_second got=%0b/%0d/%h exp=1/4/22", oWe, oWaddr, oWdata); end
    checks++; if (oPending !== 3'd0) begin errors++; $display("FAIL both_pend0 got=%0d exp=0", oPending); end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      drive(1, 10, 32'h100 + i, 1, AW'(20 + i), 32'h200 + i);
      cycle();
    end
    checks++; if (oPending !== 3'd4) begin errors++; $display("FAIL full_pending got=%0d exp=4", oPending); end
    checks++; if (oMemReady !== 1'b0 || oAluReady !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b%0b exp=00", oAluReady, oMemReady); end
    drive(1, 10, 32'h1FF, 0, 0, 0);
    cycle();
    checks++; if (oWe !== 1'b1 || oWaddr !== 5'd20 || oWdata !== 32'h200) begin
      errors++; $display("FAIL full_drain got=%0b/%0d/%h exp=1/20/200", oWe, oWaddr, oWdata); end
    checks++; if (oPending !== 3'd3 || oAluReady !== 1'b1) begin errors++; $display("FAIL full_after got=%0d/%0b exp=3/1", oPending, oAluReady); end
    cycle();
    checks++; if (oWe !== 1'b1 || oWdata !== 32'h1FF) begin errors++; $display("FAIL full_alu_resume got=%0b/%h exp=1/1ff", oWe, oWdata); end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (oWe !== 1'b1 || oWdata !== 32'h201 + i) begin errors++; $display("FAIL full_tail got=%0b/%h exp=1/%h", oWe, oWdata, 32'h201 + i); end
    end
  endtask

  task automatic test_chk();
    logic [DW-1:0] exp_d;
    drive(1, 1, 32'hA1, 1, 7, 32'h55);
    cycle();
    drive(1, 2, 32'hA2, 1, 7, 32'h66);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    iChkAddr = 7; #1;
`ifdef WB_FWD_EN
    exp_d = 32'h66;
`else
    exp_d = 32'h0;
`endif
    checks++; if (oChkHit !== 1'b1 || oChkData !== exp_d) begin errors++; $display("FAIL chk_r7 got=%0b/%h exp=1/%h", oChkHit, oChkData, exp_d); end
    iChkAddr = 0; #1;
    checks++; if (oChkHit !== 1'b0 || oChkData !== '0) begin errors++; $display("FAIL chk_r0 got=%0b/%h exp=0/0", oChkHit, oChkData); end
    iChkAddr = 2; #1;
`ifdef WB_FWD_EN
    exp_d = 32'hA2;
`else
    exp_d = 32'h0;
`endif
    checks++; if (oChkHit !== 1'b1 || oChkData !== exp_d) begin errors++; $display("FAIL chk_outreg got=%0b/%h exp=1/%h", oChkHit, oChkData, exp_d); end
    repeat (3) cycle();
    iChkAddr = 7; #1;
    checks++; if (oChkHit !== 1'b0) begin errors++; $display("FAIL chk_retired got=%0b exp=0", oChkHit); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ld_addr [10];
    int nld = 0, nseen = 0, nalu = 0, guard = 0;
    for (int i = 0; i < 10; i++) ld_addr[i] = AW'($urandom_range(1, 31));
    while (nseen < 10 && guard < 200) begin
      drive(nld < 10, AW'($urandom_range(1, 31)), 32'h5000_0000 | nalu,
            nld < 10, ld_addr[nld % 10], 32'hA000_0000 | nld);
      cycle();
      guard++;
      if (m_mem_acc) nld++;
      if (m_alu_acc) nalu++;
      checks++; if (oWe !== m_we || (m_we && (oWaddr !== m_waddr || oWdata !== m_wdata))) begin
        errors++; $display("FAIL b2b_model got=%0b/%0d/%h exp=%0b/%0d/%h", oWe, oWaddr, oWdata, m_we, m_waddr, m_wdata); end
      if (oWe === 1'b1 && oWdata[31:28] === 4'hA) begin
        checks++; if (oWdata !== (32'hA000_0000 | nseen) || oWaddr !== ld_addr[nseen % 10]) begin
          errors++; $display("FAIL b2b_order got=%0d/%h exp=%0d/%h", oWaddr, oWdata, ld_addr[nseen % 10], 32'hA000_0000 | nseen); end
        nseen++;
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (nseen != 10) begin errors++; $display("FAIL b2b_count got=%0d exp=10 (cycle budget)", nseen); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 32'hB0 + i, 1, 12, 32'hC0 + i);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (oPending !== 3'd3) begin errors++; $display("FAIL rst_mid_pre got=%0d exp=3", oPending); end
    #1 iReset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (oWe !== 1'b0 || oPending !== 3'd0) begin errors++; $display("FAIL rst_mid_state got=%0b/%0d exp=0/0", oWe, oPending); end
    checks++; if (oAluReady !== 1'b1 || oMemReady !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%0b%0b exp=11", oAluReady, oMemReady); end
    @(posedge iClk); #1 iReset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (oWe !== 1'b0) begin errors++; $display("FAIL rst_mid_stale got=%0b exp=0", oWe); end
    end
  endtask

  task automatic test_random();
    logic hit;
    logic [DW-1:0] d;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom);
      iChkAddr = AW'($urandom_range(0, 7));
      #1;
      model_chk(iChkAddr, hit, d);
      checks++; if (oChkHit !== hit || oChkData !== d) begin errors++; $display("FAIL rnd_chk got=%0b/%h exp=%0b/%h", oChkHit, oChkData, hit, d); end
      checks++; if (oPending !== 3'(mq_a.size()) || oAluReady !== (mq_a.size() != D) || oMemReady !== (mq_a.size() != D)) begin
        errors++; $display("FAIL rnd_state got=%0d/%0b%0b exp=%0d", oPending, oAluReady, oMemReady, mq_a.size()); end
      cycle();
      checks++; if (oWe !== m_we || (m_we && (oWaddr !== m_waddr || oWdata !== m_wdata))) begin
        errors++; $display("FAIL rnd_write got=%0b/%0d/%h exp=%0b/%0d/%h", oWe, oWaddr, oWdata, m_we, m_waddr, m_wdata); end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_write();
    test_alu_and_load();
    test_fifo_full();
    test_chk();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
